// File: rtl/simple_irq_cond.sv
// simple_irq_cond: per-line synchronise, polarity, glitch-filter and level/stretched-pulse
// conditioning of raw interrupt lines feeding the PIC irq inputs.
module simple_irq_cond #(
  parameter int NUM_IRQ = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_IRQ:1] POL_MASK = '0,
  parameter logic [NUM_IRQ:1] EDGE_MASK = '0,
  parameter int FILTER_CYCLES = 0,
  parameter int STRETCH_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ:1]   irq_raw_i,
  output logic [NUM_IRQ:1]   irq_o
);
  if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || NUM_IRQ < 1) begin : g_bad
    $error("simple_irq_cond: illegal parameters");
  end
  for (genvar n = 1; n <= NUM_IRQ; n++) begin : g_line
    logic [SYNC_STAGES-1:0] sync;
    logic s, f, o;
    always_ff @(posedge clk_i)
      sync <= rst_i ? '0 : {sync[SYNC_STAGES-2:0], irq_raw_i[n] ^ POL_MASK[n]};
    assign s = sync[SYNC_STAGES-1];
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign f = s;
    end else begin : g_filt
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      logic [CW-1:0] c;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          f <= 1'b0;
          c <= '0;
        end else if (s == f) begin
          c <= '0;
        end else if (c == CW'(FILTER_CYCLES - 1)) begin
          f <= s;
          c <= '0;
        end else begin
          c <= c + CW'(1);
        end
      end
    end
    if (EDGE_MASK[n]) begin : g_edge
      localparam int KW = STRETCH_CYCLES > 1 ? $clog2(STRETCH_CYCLES) : 1;
      logic fd, rise;
      logic [KW-1:0] k;
      assign rise = f & ~fd;
      // A rise reloads the stretch counter, so back-to-back rises merge into one pulse.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          fd <= 1'b0;
          k  <= '0;
          o  <= 1'b0;
        end else begin
          fd <= f;
          k  <= rise ? KW'(STRETCH_CYCLES - 1) : (k != '0 ? k - KW'(1) : k);
          o  <= rise | (k != '0);
        end
      end
    end else begin : g_level
      always_ff @(posedge clk_i) o <= rst_i ? 1'b0 : f;
    end
    assign irq_o[n] = o;
  end
endmodule

// File: tb/tb_simple_irq_cond.sv
// tb_simple_irq_cond: directed vector table plus randomized run against a history-window reference model
// for two configurations (unfiltered S=2/stretch 4, and filtered F=3/stretch 3).
module tb_simple_irq_cond;
  localparam int SP[2] = '{2, 2};
  localparam int FP[2] = '{0, 3};
  localparam int KP[2] = '{4, 3};
  localparam logic [32:1] P0 = 32'hF000_0010;
  localparam logic [32:1] E0 = 32'h00FF_0040;
  localparam logic [32:1] P1 = 32'h0F00_0100;
  localparam logic [32:1] E1 = 32'hFF00_FF00;
  localparam logic [32:1] PP[2] = '{P0, P1};
  localparam logic [32:1] EP[2] = '{E0, E1};

  logic clk = 1'b0;
  logic rst;
  logic [32:1] raw, irq_a, irq_b;
  logic [32:1] ah[2][16];
  logic [32:1] fh[2][16];
  logic [32:1] exp_o[2];
  int checks = 0, failures = 0;

  typedef struct {
    logic r;
    logic [32:1] raw;
    logic d;
    int ln;
    logic ev;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  simple_irq_cond #(.NUM_IRQ(32), .SYNC_STAGES(2), .POL_MASK(P0), .EDGE_MASK(E0),
    .FILTER_CYCLES(0), .STRETCH_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .irq_raw_i(raw), .irq_o(irq_a));

  simple_irq_cond #(.NUM_IRQ(32), .SYNC_STAGES(2), .POL_MASK(P1), .EDGE_MASK(E1),
    .FILTER_CYCLES(3), .STRETCH_CYCLES(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .irq_raw_i(raw), .irq_o(irq_b));

  // Reference: s is the polarised input delayed SYNC_STAGES-1 samples; f flips once s has
  // disagreed with it for F consecutive samples; an edge line is high while a rise of f lies
  // within the last STRETCH samples; a level line shows f one clock late.
  task automatic model_step(input int d, input logic r, input logic [32:1] v);
    logic [32:1] mism, rises, fn;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        ah[d][i] = '0;
        fh[d][i] = '0;
      end
      exp_o[d] = '0;
      return;
    end
    for (int i = 15; i > 0; i--) ah[d][i] = ah[d][i-1];
    ah[d][0] = v ^ PP[d];
    if (FP[d] == 0) fn = ah[d][SP[d]-1];
    else begin
      mism = '1;
      for (int j = 0; j < FP[d]; j++) mism &= ah[d][SP[d]+j] ^ fh[d][0];
      fn = fh[d][0] ^ mism;
    end
    rises = '0;
    for (int i = 0; i < KP[d]; i++) rises |= fh[d][i] & ~fh[d][i+1];
    exp_o[d] = (fh[d][0] & ~EP[d]) | (rises & EP[d]);
    for (int i = 15; i > 0; i--) fh[d][i] = fh[d][i-1];
    fh[d][0] = fn;
  endtask

  task automatic chk(input string nm, input logic [32:1] act, input logic [32:1] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [32:1] v);
    rst = r;
    raw = v;
    model_step(0, r, v);
    model_step(1, r, v);
    @(posedge clk);
    @(negedge clk);
    chk("model_a", irq_a, exp_o[0]);
    chk("model_b", irq_b, exp_o[1]);
  endtask

  task automatic add(input logic r, input logic [32:1] v, input logic d, input int ln, input logic ev);
    vec_t t;
    t.r = r;
    t.raw = v;
    t.d = d;
    t.ln = ln;
    t.ev = ev;
    tv.push_back(t);
  endtask

  initial begin
    logic [32:1] v, act;
    rst = 1'b1;
    raw = '0;
    add(1, 32'h10, 0, 3, 0);
    add(1, 32'h10, 0, 5, 0);
    for (int i = 1; i <= 3; i++) add(0, 32'h14, 0, 3, i == 3);
    for (int i = 1; i <= 3; i++) add(0, 32'h10, 0, 3, i < 3);
    add(0, 32'h10, 0, 5, 0);
    for (int i = 1; i <= 3; i++) add(0, 32'h0, 0, 5, i == 3);
    for (int i = 1; i <= 20; i++) add(0, 32'h40, 0, 7, i >= 3 && i <= 6);
    for (int i = 1; i <= 4; i++) add(0, 32'h0, 0, 7, 0);
    for (int i = 1; i <= 8; i++) add(0, i == 1 ? 32'h40 : 32'h0, 0, 7, i >= 3 && i <= 6);
    for (int i = 1; i <= 10; i++) add(0, (i == 1 || i == 3) ? 32'h40 : 32'h0, 0, 7, i >= 3 && i <= 8);
    for (int i = 1; i <= 8; i++) add(0, i <= 2 ? 32'h1 : 32'h0, 1, 1, 0);
    for (int i = 1; i <= 10; i++) add(0, i <= 3 ? 32'h1 : 32'h0, 1, 1, i >= 6 && i <= 8);
    @(negedge clk);
    foreach (tv[i]) begin
      tick(tv[i].r, tv[i].raw);
      act = '0;
      act[1] = tv[i].d ? irq_b[tv[i].ln] : irq_a[tv[i].ln];
      chk($sformatf("tbl%0d_d%0d_irq%0d", i, tv[i].d, tv[i].ln), act, {31'b0, tv[i].ev});
    end
    // reset in the middle of a pulse on every line, then release with all lines held high
    for (int i = 1; i <= 4; i++) tick(0, '1);
    chk("pre_rst_pulse", {31'b0, irq_a[7]}, 32'h1);
    tick(1, '1);
    chk("rst_mid_a", irq_a, '0);
    chk("rst_mid_b", irq_b, '0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, '1);
      chk($sformatf("post_rst_%0d", i), irq_a, i < 3 ? 32'h0 : (i <= 6 ? ~P0 : ~P0 & ~E0));
    end
    v = '0;
    for (int i = 0; i < 3000; i++) begin
      v ^= $urandom & $urandom & $urandom;
      tick($urandom_range(0, 299) == 0, v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
